// File: rtl/unified_mem_pkg.sv
// Shared bus encodings, memory geometry and status codes for the unified memory model
// and the pipeline that talks to it.
package unified_mem_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_e;

    localparam int NUM_MEM_TAGS    = 15;
    localparam int MEM_LATENCY     = 10;
    localparam int MEM_64BIT_LINES = 8192;
    localparam int TAG_W           = 4;

    typedef enum logic [3:0] {
        NO_ERROR               = 4'h0,
        HALTED_ON_MEMORY_ERROR = 4'h1,
        HALTED_ON_HALT         = 4'h2,
        HALTED_ON_ILLEGAL      = 4'h3
    } ERROR_CODE;

endpackage

// File: rtl/mem_tag_table.sv
// Tag bookkeeping for the split-transaction memory: lowest-free allocation,
// per-tag latency countdown, completion select and per-tag return data.
module mem_tag_table #(
    parameter int NUM_TAGS = 15,
    parameter int LATENCY  = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alloc_valid,
    input  logic [63:0] alloc_data,
    output logic        grant_ok,
    output logic [3:0]  grant_tag,
    output logic [3:0]  done_tag,
    output logic [63:0] done_data
);
    import unified_mem_pkg::*;

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);

    logic [NUM_TAGS:1] busy;
    logic [NUM_TAGS:1] expiring;
    logic [NUM_TAGS:1] avail;
    logic [CNT_W-1:0]  count [NUM_TAGS:1];
    logic [63:0]       data  [NUM_TAGS:1];

    // A tag finishing at this edge counts as free so the same edge can reuse it.
    always_comb begin
        expiring = '0;
        avail    = '0;
        for (int t = 1; t <= NUM_TAGS; t++) begin
            expiring[t] = busy[t] && (count[t] == CNT_W'(1));
            avail[t]    = !busy[t] || expiring[t];
        end
    end

    always_comb begin
        grant_ok  = 1'b0;
        grant_tag = '0;
        for (int t = NUM_TAGS; t >= 1; t--) begin
            if (avail[t]) begin
                grant_ok  = 1'b1;
                grant_tag = TAG_W'(t);
            end
        end
    end

    always_comb begin
        done_tag  = '0;
        done_data = '0;
        for (int t = 1; t <= NUM_TAGS; t++) begin
            if (expiring[t]) begin
                done_tag  = TAG_W'(t);
                done_data = data[t];
            end
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            busy <= '0;
            for (int t = 1; t <= NUM_TAGS; t++) begin
                count[t] <= '0;
                data[t]  <= '0;
            end
        end else begin
            for (int t = 1; t <= NUM_TAGS; t++) begin
                if (alloc_valid && grant_ok && (grant_tag == TAG_W'(t))) begin
                    busy[t]  <= 1'b1;
                    count[t] <= CNT_LOAD;
                    data[t]  <= alloc_data;
                end else if (expiring[t]) begin
                    busy[t] <= 1'b0;
                end else if (busy[t]) begin
                    count[t] <= count[t] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/unified_mem.sv
// Behavioural main memory on a tagged split-transaction bus, evaluated on the
// falling clock edge; the line array survives reset and can be preloaded.
module unified_mem #(
    parameter int NUM_MEM_TAGS    = unified_mem_pkg::NUM_MEM_TAGS,
    parameter int MEM_LATENCY     = unified_mem_pkg::MEM_LATENCY,
    parameter int MEM_64BIT_LINES = unified_mem_pkg::MEM_64BIT_LINES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [63:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
    output logic [3:0]  mem2proc_response,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag
);
    import unified_mem_pkg::*;

    localparam int IDX_W = $clog2(MEM_64BIT_LINES);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_64BIT_LINES) * 64'd8;

    logic [63:0] unified_memory [MEM_64BIT_LINES-1:0];

    logic [IDX_W-1:0] line_index;
    logic             is_load;
    logic             is_store;
    logic             addr_ok;
    logic             req_valid;
    logic             accept;
    logic             grant_ok;
    logic [3:0]       grant_tag;
    logic [3:0]       done_tag;
    logic [63:0]      done_data;
    logic [63:0]      alloc_data;

    assign line_index = proc2mem_addr[IDX_W+2:3];
    assign is_load    = (proc2mem_command == BUS_LOAD);
    assign is_store   = (proc2mem_command == BUS_STORE);
    assign addr_ok    = (proc2mem_addr[2:0] == 3'b000) && (proc2mem_addr < MEM_BYTES);
    assign req_valid  = (is_load || is_store) && addr_ok;
    assign accept     = req_valid && grant_ok;
    // Loads snapshot the line now, so a later store cannot change what they return.
    assign alloc_data = is_load ? unified_memory[line_index] : 64'd0;

    mem_tag_table #(
        .NUM_TAGS (NUM_MEM_TAGS),
        .LATENCY  (MEM_LATENCY)
    ) u_tags (
        .clock       (clock),
        .reset       (reset),
        .alloc_valid (req_valid),
        .alloc_data  (alloc_data),
        .grant_ok    (grant_ok),
        .grant_tag   (grant_tag),
        .done_tag    (done_tag),
        .done_data   (done_data)
    );

    // The array has no reset value: contents persist across reset.
    always_ff @(negedge clock or posedge reset) begin
        if (!reset && accept && is_store) begin
            unified_memory[line_index] <= proc2mem_data;
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            mem2proc_response <= '0;
            mem2proc_tag      <= '0;
            mem2proc_data     <= '0;
        end else begin
            mem2proc_response <= accept ? grant_tag : 4'd0;
            mem2proc_tag      <= done_tag;
            mem2proc_data     <= done_data;
        end
    end

endmodule

// File: tb/tb_unified_mem.sv
// Self-checking bench for unified_mem: directed vector table, tag exhaustion on a
// long-latency instance, mid-flight reset, and random traffic against a queue model.
module tb_unified_mem;
    import unified_mem_pkg::*;

    localparam int LAT         = 10;
    localparam int SLOW_LAT    = 20;
    localparam int MODEL_LINES = 8192;
    localparam int NTAGS       = 15;
    localparam int NVEC        = 52;

    logic        clock;
    logic        reset;
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] rdata;
    logic [3:0]  slow_resp;
    logic [3:0]  slow_tag;
    logic [63:0] slow_rdata;

    int checks = 0;
    int errors = 0;

    unified_mem dut (
        .clock             (clock),
        .reset             (reset),
        .proc2mem_command  (cmd),
        .proc2mem_addr     (addr),
        .proc2mem_data     (wdata),
        .mem2proc_response (resp),
        .mem2proc_data     (rdata),
        .mem2proc_tag      (tag)
    );

    unified_mem #(.MEM_LATENCY(SLOW_LAT)) dut_slow (
        .clock             (clock),
        .reset             (reset),
        .proc2mem_command  (cmd),
        .proc2mem_addr     (addr),
        .proc2mem_data     (wdata),
        .mem2proc_response (slow_resp),
        .mem2proc_data     (slow_rdata),
        .mem2proc_tag      (slow_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: outstanding transactions as a queue of {tag, due cycle, data}.
    typedef struct {
        logic [3:0]  tag;
        int          due;
        logic [63:0] data;
    } flight_t;

    flight_t     inflight [$];
    logic [63:0] ref_mem [0:MODEL_LINES-1];
    int          cyc = 0;
    logic [3:0]  exp_resp;
    logic [3:0]  exp_tag;
    logic [63:0] exp_data;

    typedef struct {
        logic [1:0]  cmd;
        logic [63:0] addr;
        logic [63:0] data;
        logic [3:0]  resp;
        logic [3:0]  tag;
        logic [63:0] rdata;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic bit isValid(input logic [1:0] c, input logic [63:0] a);
        return (c == BUS_LOAD || c == BUS_STORE) && (a % 64'd8 == 64'd0)
               && (a < 64'(MODEL_LINES * 8));
    endfunction

    task automatic modelStep(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d);
        bit used;
        int line;
        cyc++;
        exp_resp = 4'd0;
        exp_tag  = 4'd0;
        exp_data = 64'd0;
        for (int i = inflight.size() - 1; i >= 0; i--) begin
            if (inflight[i].due == cyc) begin
                exp_tag  = inflight[i].tag;
                exp_data = inflight[i].data;
                inflight.delete(i);
            end
        end
        if (isValid(c, a)) begin
            for (int t = 1; t <= NTAGS && exp_resp == 4'd0; t++) begin
                used = 1'b0;
                foreach (inflight[i]) if (inflight[i].tag == 4'(t)) used = 1'b1;
                if (!used) exp_resp = 4'(t);
            end
            if (exp_resp != 4'd0) begin
                line = int'(a / 64'd8);
                inflight.push_back('{exp_resp, cyc + LAT, (c == BUS_STORE) ? 64'd0 : ref_mem[line]});
                if (c == BUS_STORE) ref_mem[line] = d;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic checkAgainstModel();
        checkOutput("response", 64'(resp), 64'(exp_resp));
        checkOutput("tag", 64'(tag), 64'(exp_tag));
        checkOutput("data", rdata, exp_data);
    endtask

    // Drive at the rising edge, let the DUT evaluate at the falling edge, then sample.
    task automatic applyStimulus(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d);
        @(posedge clock);
        cmd   = c;
        addr  = a;
        wdata = d;
        @(negedge clock);
        #1;
        modelStep(c, a, d);
    endtask

    task automatic pulseReset();
        @(posedge clock);
        cmd   = BUS_NONE;
        addr  = 64'd0;
        wdata = 64'd0;
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_resp", 64'(resp), 64'd0);
        checkOutput("rst_tag", 64'(tag), 64'd0);
        checkOutput("rst_data", rdata, 64'd0);
        checkOutput("rst_slow_resp", 64'(slow_resp), 64'd0);
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        inflight.delete();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        int k;
        int line;
        logic [1:0]  c;
        logic [63:0] a;

        cmd   = BUS_NONE;
        addr  = 64'd0;
        wdata = 64'd0;
        reset = 1'b0;
        #1 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1;
        checkOutput("init_resp", 64'(resp), 64'd0);
        checkOutput("init_tag", 64'(tag), 64'd0);
        checkOutput("init_data", rdata, 64'd0);
        checkOutput("init_slow_tag", 64'(slow_tag), 64'd0);
        #2 reset = 1'b0;

        // Directed table: one entry per falling edge, idle unless overwritten.
        for (int i = 0; i < NVEC; i++) vecs[i] = '{BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0};
        vecs[0]  = '{BUS_STORE, 64'd16, 64'hDEAD_BEEF, 4'd1, 4'd0, 64'd0};
        vecs[10] = '{BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd1, 64'd0};
        vecs[11] = '{BUS_LOAD, 64'd16, 64'd0, 4'd1, 4'd0, 64'd0};
        vecs[21] = '{BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd1, 64'hDEAD_BEEF};
        vecs[22] = '{BUS_STORE, 64'd8, 64'd5, 4'd1, 4'd0, 64'd0};
        vecs[23] = '{BUS_LOAD, 64'd8, 64'd0, 4'd2, 4'd0, 64'd0};
        vecs[32] = '{BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd1, 64'd0};
        vecs[33] = '{BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd2, 64'd5};
        vecs[34] = '{BUS_LOAD, 64'd9, 64'd0, 4'd0, 4'd0, 64'd0};
        vecs[35] = '{BUS_LOAD, 64'd65536, 64'd0, 4'd0, 4'd0, 64'd0};
        vecs[36] = '{2'd3, 64'd8, 64'd77, 4'd0, 4'd0, 64'd0};
        vecs[37] = '{BUS_NONE, 64'd8, 64'd99, 4'd0, 4'd0, 64'd0};
        vecs[38] = '{BUS_LOAD, 64'd8, 64'd0, 4'd1, 4'd0, 64'd0};
        vecs[39] = '{BUS_STORE, 64'd8, 64'd6, 4'd2, 4'd0, 64'd0};
        vecs[48] = '{BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd1, 64'd5};
        vecs[49] = '{BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd2, 64'd0};
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].cmd, vecs[i].addr, vecs[i].data);
            checkOutput($sformatf("vec%0d_resp", i), 64'(resp), 64'(vecs[i].resp));
            checkOutput($sformatf("vec%0d_tag", i), 64'(tag), 64'(vecs[i].tag));
            checkOutput($sformatf("vec%0d_data", i), rdata, vecs[i].rdata);
        end

        // Back-to-back loads: all tags busy on the slow instance, reuse at completion.
        pulseReset();
        for (int i = 0; i < 22; i++) begin
            applyStimulus(BUS_LOAD, 64'd8, 64'd0);
            checkAgainstModel();
            checkOutput($sformatf("slow%0d_resp", i), 64'(slow_resp),
                        (i < NTAGS) ? 64'(i + 1) : (i == 20) ? 64'd1 : (i == 21) ? 64'd2 : 64'd0);
            checkOutput($sformatf("slow%0d_tag", i), 64'(slow_tag),
                        (i == 20) ? 64'd1 : (i == 21) ? 64'd2 : 64'd0);
            checkOutput($sformatf("slow%0d_data", i), slow_rdata,
                        (i >= 20) ? ref_mem[1] : 64'd0);
        end

        // Reset with tags 1..3 in flight: nothing may be broadcast afterwards.
        pulseReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(BUS_LOAD, 64'd8, 64'd0);
            checkAgainstModel();
        end
        pulseReset();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(BUS_NONE, 64'd0, 64'd0);
            checkAgainstModel();
        end
        applyStimulus(BUS_LOAD, 64'd8, 64'd0);
        checkAgainstModel();
        checkOutput("post_reset_first_tag", 64'(resp), 64'd1);

        // Random traffic over a small window of lines, initialised first.
        for (int l = 0; l < 64; l++) begin
            applyStimulus(BUS_STORE, 64'(l * 8), {$urandom, $urandom});
            checkAgainstModel();
        end
        for (int n = 0; n < 400; n++) begin
            r    = $urandom_range(0, 9);
            k    = $urandom_range(0, 9);
            line = $urandom_range(0, 63);
            c = (r < 4) ? BUS_LOAD : (r < 8) ? BUS_STORE : (r == 8) ? BUS_NONE : 2'd3;
            a = (k == 0) ? 64'(line * 8 + $urandom_range(1, 7)) :
                (k == 1) ? 64'(65536 + line * 8) : 64'(line * 8);
            applyStimulus(c, a, {$urandom, $urandom});
            checkAgainstModel();
        end
        for (int n = 0; n < 12; n++) begin
            applyStimulus(BUS_NONE, 64'd0, 64'd0);
            checkAgainstModel();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
